// File: rtl/alu_8_result_buf.sv
// alu_8_result_buf: two-entry FIFO that buffers ALU results together with flags derived at push time
module alu_8_result_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_result,
  input  logic       in_carry,
  input  logic [3:0] in_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic [3:0] out_flags,
  output logic [1:0] count,
  output logic [7:0] ops_done,
  output logic       ovf_err
);
  logic [11:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        push;
  logic        pop;
  logic [3:0]  flags;
  // handshakes come from registered occupancy only; flags are {illegal, neg, zero, carry}
  always_comb begin
    in_ready   = cnt != 2'd2;
    out_valid  = cnt != 2'd0;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    flags      = {~in_sel[2], in_result[7], in_result == 8'd0, in_carry & in_sel[3]};
    out_result = out_valid ? mem[rd_ptr][11:4] : 8'd0;
    out_flags  = out_valid ? mem[rd_ptr][3:0] : 4'd0;
    count      = cnt;
  end
  // storage, pointers, occupancy, pop counter and sticky overflow; reset wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= 12'd0;
      mem[1]   <= 12'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      ops_done <= 8'd0;
      ovf_err  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_result, flags};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        ops_done <= ops_done + 8'd1;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (in_valid && cnt == 2'd2) ovf_err <= 1'b1;
    end
  end
endmodule

// File: doc/alu_8_result_buf.md
ALU_8_RESULT_BUF -- requirements
Module: alu_8_result_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream ALU result is valid this cycle.
REQ-005 in_ready  output  1  buffer can accept a result this cycle.
REQ-006 in_result  input  8  ALU result byte.
REQ-007 in_carry  input  1  ALU carry/borrow bit.
REQ-008 in_sel  input  4  ALU opcode that produced the result.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream consumes head entry.
REQ-011 out_result  output  8  head result byte.
REQ-012 out_flags  output  4  head flags {illegal, neg, zero, carry}, with bit 3 = illegal.
REQ-013 count  output  2  current occupancy, 0 to 2.
REQ-014 ops_done  output  8  popped-entry counter, wraps modulo 256.
REQ-015 ovf_err  output  1  sticky flag for a push attempt while full.

Function
REQ-016 Storage SHALL be a 2-entry FIFO of {result[7:0], flags[3:0]}.
REQ-017 Push SHALL occur when in_valid and in_ready are both 1.
REQ-018 Pop SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL equal (count != 2) and SHALL have no combinational dependence on out_ready or in_valid.
REQ-020 out_valid SHALL equal (count != 0), driven from registered state only.
REQ-021 Flags SHALL be computed at push from the input values:
  - zero = (in_result == 0)
  - neg = in_result[7]
  - carry = in_carry AND in_sel[3] (logical ops always store carry 0)
  - illegal = NOT in_sel[2] (sel[2:0] in 000 to 011)
REQ-022 Latency SHALL be 1 cycle: a push into an empty buffer SHALL make out_valid 1 on the next cycle, with that entry at the head.
REQ-023 out_result and out_flags SHALL present the head entry and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When out_valid=0, out_result and out_flags SHALL be 0.
REQ-025 A simultaneous push and pop with count=1 SHALL leave count at 1; the new entry becomes head on the next cycle.
REQ-026 With count=2, a push cannot occur because in_ready=0; a pop SHALL make count 1 and in_ready 1 on the next cycle.
REQ-027 A pop with count=0 cannot occur because out_valid=0; out_ready SHALL be ignored.
REQ-028 Entry order SHALL be strictly first in, first out; read and write pointers SHALL wrap 1 to 0.
REQ-029 ops_done SHALL increment by 1 on every pop and SHALL wrap from 255 to 0.
REQ-030 ovf_err SHALL set to 1 on any cycle with in_valid=1 and count=2, and SHALL stay 1 until reset.
REQ-031 The input data of a rejected push SHALL be dropped without altering any stored entry.

Reset
REQ-032 On rst_n=0 at a clock edge, the following SHALL all become 0: count, pointers, ops_done, ovf_err, out_valid, out_result, out_flags.
REQ-033 in_ready SHALL be 1 on the first cycle after reset.
REQ-034 Reset SHALL take priority over a push or pop in the same cycle.
REQ-035 Reset asserted mid-operation SHALL discard all stored entries.
REQ-036 No output SHALL take an unknown value after the first reset edge.

Verification
REQ-037 Bench SHALL cover: push {result=8'h00, carry=1, sel=4'b0111} into empty -> next cycle out_valid=1, out_result=8'h00, out_flags=4'b0010 (zero=1, carry masked to 0).
REQ-038 Bench SHALL cover: push 8'h80/carry=1/sel=4'b1111, then 8'h05/carry=0/sel=4'b1101, with out_ready=0 -> count=2, in_ready=0, head=8'h80 with flags 4'b0101.
REQ-039 Bench SHALL cover, continuing from REQ-038: assert in_valid=1 while full -> ovf_err=1 and stays 1; then out_ready=1 for two cycles -> outputs 8'h80 then 8'h05, ops_done=2, count=0.
REQ-040 Bench SHALL cover: count=1, push and pop in the same cycle -> count stays 1; head is the new entry next cycle.
REQ-041 Bench SHALL cover: push sel=4'b1011 with result 8'h00 -> out_flags=4'b1010 (illegal=1, zero=1).
REQ-042 Bench SHALL cover: 256 pops -> ops_done wraps to 8'h00; rst_n=0 with count=2 -> next cycle count=0, out_valid=0, ovf_err=0.
